// File: rtl/imuldiv_muldiv_frontend.sv
// Muldiv front end: steers requests to the multiply or divide unit and merges
// their responses back into issue order using a small tag FIFO.
module imuldiv_muldiv_frontend #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic [1:0]  muldivreq_msg_fn,
   input  logic [31:0] muldivreq_msg_a,
   input  logic [31:0] muldivreq_msg_b,
   input  logic        muldivreq_val,
   output logic        muldivreq_rdy,

   output logic [63:0] muldivresp_msg_result,
   output logic        muldivresp_val,
   input  logic        muldivresp_rdy,

   output logic [31:0] mulreq_msg_a,
   output logic [31:0] mulreq_msg_b,
   output logic        mulreq_val,
   input  logic        mulreq_rdy,

   input  logic [63:0] mulresp_msg_result,
   input  logic        mulresp_val,
   output logic        mulresp_rdy,

   output logic        divreq_msg_fn,
   output logic [31:0] divreq_msg_a,
   output logic [31:0] divreq_msg_b,
   output logic        divreq_val,
   input  logic        divreq_rdy,

   input  logic [63:0] divresp_msg_result,
   input  logic        divresp_val,
   output logic        divresp_rdy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      TAG_MUL  = 2'd0,
      TAG_DIV  = 2'd1,
      TAG_ZERO = 2'd2
   } tag_t;

   tag_t          tag_mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   tag_t          push_tag;
   tag_t          head_tag;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   assign mulreq_msg_a  = muldivreq_msg_a;
   assign mulreq_msg_b  = muldivreq_msg_b;
   assign divreq_msg_a  = muldivreq_msg_a;
   assign divreq_msg_b  = muldivreq_msg_b;
   assign divreq_msg_fn = ~muldivreq_msg_fn[1];

   always_comb begin
      mulreq_val    = 1'b0;
      divreq_val    = 1'b0;
      muldivreq_rdy = 1'b0;
      push_tag      = TAG_ZERO;
      case (muldivreq_msg_fn)
         2'b00: begin
            mulreq_val    = muldivreq_val & ~full;
            muldivreq_rdy = mulreq_rdy & ~full;
            push_tag      = TAG_MUL;
         end
         2'b01, 2'b10: begin
            divreq_val    = muldivreq_val & ~full;
            muldivreq_rdy = divreq_rdy & ~full;
            push_tag      = TAG_DIV;
         end
         default: begin
            muldivreq_rdy = ~full;
            push_tag      = TAG_ZERO;
         end
      endcase
   end

   assign push     = muldivreq_val & muldivreq_rdy;
   assign head_tag = tag_mem[rptr];

   // Only the unit whose tag is at the head may hand over a result.
   always_comb begin
      muldivresp_val        = 1'b0;
      muldivresp_msg_result = 64'h0;
      mulresp_rdy           = 1'b0;
      divresp_rdy           = 1'b0;
      if (!empty) begin
         case (head_tag)
            TAG_MUL: begin
               muldivresp_val        = mulresp_val;
               muldivresp_msg_result = mulresp_msg_result;
               mulresp_rdy           = muldivresp_rdy;
            end
            TAG_DIV: begin
               muldivresp_val        = divresp_val;
               muldivresp_msg_result = divresp_msg_result;
               divresp_rdy           = muldivresp_rdy;
            end
            TAG_ZERO: begin
               muldivresp_val        = 1'b1;
               muldivresp_msg_result = 64'h0;
            end
            default: begin
               muldivresp_val        = 1'b0;
               muldivresp_msg_result = 64'h0;
            end
         endcase
      end
   end

   assign pop = muldivresp_val & muldivresp_rdy;

   always_ff @(posedge clk) begin
      if (push) tag_mem[wptr] <= push_tag;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_imuldiv_muldiv_frontend.sv
// Directed bench for the muldiv front end; the bench itself plays both
// arithmetic units by driving their handshakes and result buses.
module tb_imuldiv_muldiv_frontend;

   logic        clk;
   logic        reset;
   logic [1:0]  muldivreq_msg_fn;
   logic [31:0] muldivreq_msg_a;
   logic [31:0] muldivreq_msg_b;
   logic        muldivreq_val;
   logic        muldivreq_rdy;
   logic [63:0] muldivresp_msg_result;
   logic        muldivresp_val;
   logic        muldivresp_rdy;
   logic [31:0] mulreq_msg_a;
   logic [31:0] mulreq_msg_b;
   logic        mulreq_val;
   logic        mulreq_rdy;
   logic [63:0] mulresp_msg_result;
   logic        mulresp_val;
   logic        mulresp_rdy;
   logic        divreq_msg_fn;
   logic [31:0] divreq_msg_a;
   logic [31:0] divreq_msg_b;
   logic        divreq_val;
   logic        divreq_rdy;
   logic [63:0] divresp_msg_result;
   logic        divresp_val;
   logic        divresp_rdy;

   int tests;
   int failed;

   imuldiv_muldiv_frontend #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
      .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val),
      .muldivreq_rdy(muldivreq_rdy),
      .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
      .muldivresp_rdy(muldivresp_rdy),
      .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b),
      .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
      .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
      .mulresp_rdy(mulresp_rdy),
      .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a),
      .divreq_msg_b(divreq_msg_b), .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
      .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
      .divresp_rdy(divresp_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and checks happen 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      failed = 0;
      reset = 1'b1;
      muldivreq_msg_fn = 2'b00;
      muldivreq_msg_a = '0;
      muldivreq_msg_b = '0;
      muldivreq_val = 1'b0;
      muldivresp_rdy = 1'b1;
      mulreq_rdy = 1'b1;
      mulresp_msg_result = '0;
      mulresp_val = 1'b0;
      divreq_rdy = 1'b1;
      divresp_msg_result = '0;
      divresp_val = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;

      check("rst_resp_val", 64'(muldivresp_val), 64'd0);
      check("rst_mulreq_val", 64'(mulreq_val), 64'd0);
      check("rst_divreq_val", 64'(divreq_val), 64'd0);
      check("rst_mulresp_rdy", 64'(mulresp_rdy), 64'd0);
      check("rst_divresp_rdy", 64'(divresp_rdy), 64'd0);

      // MUL 6*7
      muldivreq_msg_fn = 2'b00; muldivreq_msg_a = 32'd6; muldivreq_msg_b = 32'd7;
      muldivreq_val = 1'b1;
      #1;
      check("mul_req_val", 64'(mulreq_val), 64'd1);
      check("mul_div_idle", 64'(divreq_val), 64'd0);
      check("mul_req_rdy", 64'(muldivreq_rdy), 64'd1);
      check("mul_fwd_a", 64'(mulreq_msg_a), 64'd6);
      check("mul_fwd_b", 64'(mulreq_msg_b), 64'd7);
      step();
      muldivreq_val = 1'b0;
      #1;
      check("mul_wait_val", 64'(muldivresp_val), 64'd0);
      check("mul_head_rdy", 64'(mulresp_rdy), 64'd1);
      mulresp_val = 1'b1; mulresp_msg_result = 64'h2A;
      #1;
      check("mul_resp_val", 64'(muldivresp_val), 64'd1);
      check("mul_result", muldivresp_msg_result, 64'h0000_0000_0000_002A);
      check("mul_divrdy_low", 64'(divresp_rdy), 64'd0);
      step();
      #1;
      check("mul_empty_val", 64'(muldivresp_val), 64'd0);
      check("mul_empty_rdy", 64'(mulresp_rdy), 64'd0);
      mulresp_val = 1'b0;

      // Signed DIV -7 / 2
      muldivreq_msg_fn = 2'b01; muldivreq_msg_a = 32'hFFFF_FFF9; muldivreq_msg_b = 32'd2;
      muldivreq_val = 1'b1;
      #1;
      check("div_req_val", 64'(divreq_val), 64'd1);
      check("div_fn_signed", 64'(divreq_msg_fn), 64'd1);
      check("div_mul_idle", 64'(mulreq_val), 64'd0);
      check("div_fwd_a", 64'(divreq_msg_a), 64'hFFFF_FFF9);
      step();
      muldivreq_val = 1'b0;
      divresp_val = 1'b1; divresp_msg_result = 64'hFFFF_FFFF_FFFF_FFFD;
      #1;
      check("div_resp_val", 64'(muldivresp_val), 64'd1);
      check("div_result", muldivresp_msg_result, 64'hFFFF_FFFF_FFFF_FFFD);
      check("div_head_rdy", 64'(divresp_rdy), 64'd1);
      step();
      divresp_val = 1'b0;
      #1;
      check("div_empty_val", 64'(muldivresp_val), 64'd0);

      // Ordering: MUL(3,5) then DIVU(9,2); divider answers first
      muldivreq_msg_fn = 2'b00; muldivreq_msg_a = 32'd3; muldivreq_msg_b = 32'd5;
      muldivreq_val = 1'b1;
      step();
      muldivreq_msg_fn = 2'b10; muldivreq_msg_a = 32'd9; muldivreq_msg_b = 32'd2;
      #1;
      check("ord_divu_val", 64'(divreq_val), 64'd1);
      check("ord_divu_fn", 64'(divreq_msg_fn), 64'd0);
      step();
      muldivreq_val = 1'b0;
      divresp_val = 1'b1; divresp_msg_result = 64'h0000_0001_0000_0004;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("ord_div_held", 64'(divresp_rdy), 64'd0);
         check("ord_resp_wait", 64'(muldivresp_val), 64'd0);
         step();
      end
      mulresp_val = 1'b1; mulresp_msg_result = 64'hF;
      #1;
      check("ord_mul_first", muldivresp_msg_result, 64'hF);
      check("ord_mul_val", 64'(muldivresp_val), 64'd1);
      check("ord_div_still_held", 64'(divresp_rdy), 64'd0);
      step();
      mulresp_val = 1'b0;
      #1;
      check("ord_div_second", muldivresp_msg_result, 64'h0000_0001_0000_0004);
      check("ord_div_val", 64'(muldivresp_val), 64'd1);
      check("ord_div_rdy", 64'(divresp_rdy), 64'd1);
      step();
      divresp_val = 1'b0;
      #1;
      check("ord_empty", 64'(muldivresp_val), 64'd0);

      // Full: four ZERO tags under back-pressure, fifth refused
      muldivresp_rdy = 1'b0;
      muldivreq_msg_fn = 2'b11; muldivreq_val = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("full_accept", 64'(muldivreq_rdy), 64'd1);
         check("full_no_unit", 64'(mulreq_val | divreq_val), 64'd0);
         step();
      end
      #1;
      check("full_fifth_blocked", 64'(muldivreq_rdy), 64'd0);
      check("full_head_val", 64'(muldivresp_val), 64'd1);
      step();
      muldivresp_rdy = 1'b1;
      #1;
      check("full_pop1_val", 64'(muldivresp_val), 64'd1);
      check("full_pop1_data", muldivresp_msg_result, 64'h0);
      check("full_pop1_no_push", 64'(muldivreq_rdy), 64'd0);
      step();
      check("full_fifth_accept", 64'(muldivreq_rdy), 64'd1);
      check("full_pop2_val", 64'(muldivresp_val), 64'd1);
      step();
      muldivreq_val = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("full_drain_val", 64'(muldivresp_val), 64'd1);
         check("full_drain_data", muldivresp_msg_result, 64'h0);
         step();
      end
      check("full_drained", 64'(muldivresp_val), 64'd0);

      // Reset with two tags outstanding
      muldivresp_rdy = 1'b0;
      muldivreq_msg_fn = 2'b11; muldivreq_val = 1'b1;
      step();
      step();
      muldivreq_val = 1'b0;
      #1;
      check("rstmid_pending", 64'(muldivresp_val), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("rstmid_val", 64'(muldivresp_val), 64'd0);
      muldivreq_msg_fn = 2'b11; muldivreq_val = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rstmid_count0_accept", 64'(muldivreq_rdy), 64'd1);
         step();
      end
      muldivreq_val = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      muldivresp_rdy = 1'b1;
      muldivreq_msg_fn = 2'b00; muldivreq_msg_a = 32'd2; muldivreq_msg_b = 32'd2;
      muldivreq_val = 1'b1;
      step();
      muldivreq_val = 1'b0;
      mulresp_val = 1'b1; mulresp_msg_result = 64'h4;
      #1;
      check("rstmid_mul_val", 64'(muldivresp_val), 64'd1);
      check("rstmid_mul_result", muldivresp_msg_result, 64'h4);
      step();
      mulresp_val = 1'b0;

      // Unit back-pressure on the multiplier
      mulreq_rdy = 1'b0;
      muldivreq_msg_fn = 2'b00; muldivreq_msg_a = 32'd11; muldivreq_msg_b = 32'd9;
      muldivreq_val = 1'b1;
      #1;
      check("bp_rdy_low", 64'(muldivreq_rdy), 64'd0);
      check("bp_mulreq_val", 64'(mulreq_val), 64'd1);
      step();
      muldivreq_val = 1'b0;
      mulresp_val = 1'b1; mulresp_msg_result = 64'd99;
      #1;
      check("bp_no_push", 64'(mulresp_rdy), 64'd0);
      check("bp_no_resp", 64'(muldivresp_val), 64'd0);
      mulresp_val = 1'b0;
      mulreq_rdy = 1'b1;
      muldivreq_val = 1'b1;
      #1;
      check("bp_rdy_high", 64'(muldivreq_rdy), 64'd1);
      step();
      muldivreq_val = 1'b0;
      mulresp_val = 1'b1;
      #1;
      check("bp_resp_val", 64'(muldivresp_val), 64'd1);
      check("bp_resp_data", muldivresp_msg_result, 64'd99);
      step();
      mulresp_val = 1'b0;
      #1;
      check("bp_empty", 64'(muldivresp_val), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/imuldiv_muldiv_frontend.md
Name: imuldiv_muldiv_frontend

Overview:
Request dispatcher and in-order response merger placed in front of the iterative multiply unit and the iterative divide unit. It takes one muldiv request stream and decodes its function field. Each request is steered to the correct unit over a val/rdy handshake. Returned results go out on a single response stream in issue order, with the path order tracked by a tag FIFO.

Parameters:
DEPTH, 4, number of outstanding requests tracked (tag FIFO entries, power of two, 2 to 16)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
muldivreq_msg_fn  in  2  00 MUL, 01 DIV (signed), 10 DIVU (unsigned), 11 reserved
muldivreq_msg_a  in  32  operand A
muldivreq_msg_b  in  32  operand B
muldivreq_val  in  1  request valid
muldivreq_rdy  out  1  request ready
muldivresp_msg_result  out  64  result: MUL full 64-bit signed product; DIV/DIVU {remainder[31:0], quotient[31:0]}
muldivresp_val  out  1  response valid
muldivresp_rdy  in  1  response ready
mulreq_msg_a, mulreq_msg_b  out  32 each  operands to multiplier
mulreq_val  out  1  / mulreq_rdy  in  1
mulresp_msg_result  in  64  / mulresp_val  in  1  / mulresp_rdy  out  1
divreq_msg_fn  out  1  1 = signed divide
divreq_msg_a, divreq_msg_b  out  32 each
divreq_val  out  1  / divreq_rdy  in  1
divresp_msg_result  in  64  / divresp_val  in  1  / divresp_rdy  out  1

Behaviour:
- Clock clk. Reset is reset: synchronous, active-high. Reset empties the tag FIFO (count=0, read/write pointers=0). Outputs after reset: muldivresp_val=0, mulreq_val=0, divreq_val=0, mulresp_rdy=0, divresp_rdy=0.
- Tag FIFO: DEPTH entries of 2-bit tag (MUL=0, DIV=1, ZERO=2). Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits. full = (count==DEPTH), empty = (count==0).
- Dispatch is combinational, zero added latency, no bypass when full:
  - fn 00: mulreq_val = muldivreq_val & !full. muldivreq_rdy = mulreq_rdy & !full.
  - fn 01/10: divreq_val = muldivreq_val & !full. muldivreq_rdy = divreq_rdy & !full. divreq_msg_fn = ~fn[1].
  - fn 11: no unit request. muldivreq_rdy = !full.
  - The idle unit's req_val is 0. Operands are forwarded unmodified to both units.
- Push: on muldivreq_val & muldivreq_rdy, write tag (fn 00 → MUL, 01/10 → DIV, 11 → ZERO) at wptr.
- Response merge, selected by the head tag when not empty:
  - MUL: muldivresp_val = mulresp_val. Result = mulresp_msg_result. mulresp_rdy = muldivresp_rdy.
  - DIV: same mapping using the div* signals.
  - ZERO: muldivresp_val = 1, result = 64'h0.
  - Empty: muldivresp_val = 0, result = 0.
  - The resp_rdy of the unit not at head is held 0. A unit response that arrives early waits in that unit.
- Pop: on muldivresp_val & muldivresp_rdy.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, push is blocked even if a pop occurs in the same cycle.
- Back-pressure: while muldivresp_rdy=0, the head stays and the FIFO keeps accepting requests until full.
- Reset mid-operation: in-flight tags are discarded. The units share reset, so no stale responses survive.
- Units are assumed single-outstanding internally; ordering across units relies solely on the FIFO.

Test Plan:
- MUL a=6, b=7 → mulreq_val pulses with a/b forwarded. Output 64'h0000_0000_0000_002A. FIFO empty afterwards.
- DIV a=-7 (32'hFFFF_FFF9), b=2, unit stub returns 64'hFFFF_FFFF_FFFF_FFFD → divreq_msg_fn=1. Output equals stub value.
- Ordering: issue MUL(3,5) then DIVU(9,2). Div stub responds 10 cycles before mul stub. Required:
  - divresp_rdy stays 0 until the MUL result 64'hF is output.
  - The DIVU result 64'h0000_0001_0000_0004 follows.
- Full: muldivresp_rdy=0, issue 4 fn=11 requests → all accepted, 5th sees muldivreq_rdy=0. Raise rdy → four 64'h0 responses on consecutive cycles, and the 5th is accepted in the cycle after the first pop.
- Reset with 2 tags outstanding → next cycle muldivresp_val=0, count=0. A new MUL(2,2) returns 64'h4.
- Unit back-pressure: mulreq_rdy=0 with fn=00 → muldivreq_rdy=0, no push. Accepted once mulreq_rdy=1.
